// File: rtl/swin_pkg.sv
// Shared constants for the K-row sliding-window line buffer.
package swin_pkg;
   localparam int   SWIN_WORD_W      = 128;
   localparam int   SWIN_K_MAX       = 8;
   localparam logic BORDER_SUPPRESS  = 1'b0;
   localparam logic BORDER_REPLICATE = 1'b1;
endpackage

// File: rtl/swin_lb_ram.sv
// Simple dual-port line RAM: read-first, registered read with read enable.
module swin_lb_ram #(
   parameter int WORD_W = 128,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];

   // Non-blocking read and write on the same edge returns the old word.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
   end
endmodule

// File: rtl/swin_lbuf_k.sv
// K-row sliding-window line buffer: K-1 line RAMs, two-stage pipeline,
// runtime line length, frame resync and top-border suppress/replicate.
module swin_lbuf_k
   import swin_pkg::*;
#(
   parameter int WORD_W         = SWIN_WORD_W,
   parameter int K              = 3,
   parameter int MAX_LINE_WORDS = 512,
   parameter int ADDR_W         = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W:0]       cfg_line_words,
   input  logic                  cfg_border,
   input  logic [WORD_W-1:0]     in_data,
   input  logic                  in_vld,
   input  logic                  in_sof,
   output logic                  in_rdy,
   output logic [K*WORD_W-1:0]   out_data,
   output logic                  out_vld,
   output logic                  out_eol,
   input  logic                  out_rdy
);
   localparam int NR    = K - 1;
   localparam int ROW_W = $clog2(K);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(K - 1);
   localparam logic [ROW_W-1:0] WSEL_LAST = ROW_W'(K - 2);
   localparam logic [ADDR_W:0]  LW_MAX    = (ADDR_W + 1)'(MAX_LINE_WORDS);

   logic [ADDR_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d, wsel_q, wsel_d;
   logic [ADDR_W:0]     lw_q, lw_d;
   logic                border_q, border_d;
   logic                s0_vld_q, s0_vld_d, s0_eol_q, s0_eol_d, s0_border_q, s0_border_d;
   logic [WORD_W-1:0]   s0_data_q, s0_data_d;
   logic [ROW_W-1:0]    s0_row_q, s0_row_d, s0_wsel_q, s0_wsel_d;
   logic                out_vld_q, out_vld_d, out_eol_q, out_eol_d;
   logic [K*WORD_W-1:0] out_data_q, out_data_d;

   logic                adv, accept, at_eol, eff_border;
   logic [ADDR_W-1:0]   eff_col;
   logic [ROW_W-1:0]    eff_row, eff_wsel;
   logic [ADDR_W:0]     eff_lw;
   logic [WORD_W-1:0]   ram_rd [NR];
   logic [WORD_W-1:0]   rows   [K];
   logic [K*WORD_W-1:0] win;
   int                  src;

   assign in_rdy   = adv;
   assign out_vld  = out_vld_q;
   assign out_eol  = out_eol_q;
   assign out_data = out_data_q;

   // A sof word sees zeroed counters and the freshly sampled configuration.
   always_comb begin
      adv        = !out_vld_q || out_rdy;
      accept     = in_vld && adv;
      eff_col    = in_sof ? '0 : col_q;
      eff_row    = in_sof ? '0 : row_q;
      eff_wsel   = in_sof ? '0 : wsel_q;
      eff_border = in_sof ? cfg_border : border_q;
      if (in_sof)
         eff_lw = (cfg_line_words == '0 || cfg_line_words > LW_MAX) ? LW_MAX : cfg_line_words;
      else
         eff_lw = lw_q;
      at_eol = ({1'b0, eff_col} == eff_lw - 1'b1);
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      wsel_d      = wsel_q;
      lw_d        = lw_q;
      border_d    = border_q;
      s0_vld_d    = s0_vld_q;
      s0_data_d   = s0_data_q;
      s0_eol_d    = s0_eol_q;
      s0_row_d    = s0_row_q;
      s0_wsel_d   = s0_wsel_q;
      s0_border_d = s0_border_q;
      out_vld_d   = out_vld_q;
      out_eol_d   = out_eol_q;
      out_data_d  = out_data_q;
      if (accept) begin
         col_d    = at_eol ? '0 : eff_col + 1'b1;
         row_d    = (at_eol && eff_row != ROW_LAST) ? eff_row + 1'b1 : eff_row;
         wsel_d   = at_eol ? ((eff_wsel == WSEL_LAST) ? '0 : eff_wsel + 1'b1) : eff_wsel;
         lw_d     = eff_lw;
         border_d = eff_border;
      end
      if (adv) begin
         s0_vld_d    = accept && (eff_border == BORDER_REPLICATE || eff_row == ROW_LAST);
         s0_data_d   = in_data;
         s0_eol_d    = at_eol;
         s0_row_d    = eff_row;
         s0_wsel_d   = eff_wsel;
         s0_border_d = eff_border;
         out_vld_d   = s0_vld_q;
         out_eol_d   = s0_vld_q && s0_eol_q;
         out_data_d  = win;
      end
   end

   // RAM[wsel] holds the oldest line, so rotating from wsel orders rows by age.
   always_comb begin
      rows = '{default: '0};
      win  = '0;
      rows[K-1] = s0_data_q;
      for (int i = 0; i < NR; i++)
         rows[i] = ram_rd[(int'(s0_wsel_q) + i) % NR];
      src = K - 1 - int'(s0_row_q);
      for (int i = 0; i < K; i++)
         win[WORD_W*i +: WORD_W] = (s0_border_q && i < src) ? rows[src] : rows[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         wsel_q      <= '0;
         lw_q        <= LW_MAX;
         border_q    <= BORDER_SUPPRESS;
         s0_vld_q    <= 1'b0;
         s0_data_q   <= '0;
         s0_eol_q    <= 1'b0;
         s0_row_q    <= '0;
         s0_wsel_q   <= '0;
         s0_border_q <= 1'b0;
         out_vld_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         wsel_q      <= wsel_d;
         lw_q        <= lw_d;
         border_q    <= border_d;
         s0_vld_q    <= s0_vld_d;
         s0_data_q   <= s0_data_d;
         s0_eol_q    <= s0_eol_d;
         s0_row_q    <= s0_row_d;
         s0_wsel_q   <= s0_wsel_d;
         s0_border_q <= s0_border_d;
         out_vld_q   <= out_vld_d;
         out_eol_q   <= out_eol_d;
         out_data_q  <= out_data_d;
      end
   end

   for (genvar g = 0; g < NR; g++) begin : g_ram
      logic we;
      assign we = accept && (eff_wsel == ROW_W'(g));
      swin_lb_ram #(
         .WORD_W (WORD_W),
         .DEPTH  (MAX_LINE_WORDS),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clk   (clk),
         .we    (we),
         .waddr (eff_col),
         .wdata (in_data),
         .re    (adv),
         .raddr (eff_col),
         .rdata (ram_rd[g])
      );
   end
endmodule

// File: tb/tb_swin_lbuf_k.sv
// Scoreboard bench for swin_lbuf_k (K=3, 16-bit words, 8-word line RAMs).
module tb_swin_lbuf_k;
   localparam int W    = 16;
   localparam int K    = 3;
   localparam int MAXW = 8;
   localparam int AW   = 3;
   localparam int EW   = K * W + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [AW:0]       cfg_line_words = '0;
   logic              cfg_border = 1'b0;
   logic [W-1:0]      in_data = '0;
   logic              in_vld = 1'b0;
   logic              in_sof = 1'b0;
   logic              in_rdy;
   logic [K*W-1:0]    out_data;
   logic              out_vld;
   logic              out_eol;
   logic              out_rdy = 1'b1;

   int                checks = 0;
   int                errors = 0;
   logic [EW-1:0]     exp_q[$];
   bit                ignore = 1'b0;
   int                rdy_mode = 0;
   int                cyc = 0;
   logic              prev_stall = 1'b0;
   logic [K*W-1:0]    prev_data = '0;
   logic [EW-1:0]     exp_v;

   always #5 clk = ~clk;

   swin_lbuf_k #(
      .WORD_W         (W),
      .K              (K),
      .MAX_LINE_WORDS (MAXW),
      .ADDR_W         (AW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_line_words (cfg_line_words),
      .cfg_border     (cfg_border),
      .in_data        (in_data),
      .in_vld         (in_vld),
      .in_sof         (in_sof),
      .in_rdy         (in_rdy),
      .out_data       (out_data),
      .out_vld        (out_vld),
      .out_eol        (out_eol),
      .out_rdy        (out_rdy)
   );

   function automatic logic [EW-1:0] mk(input int r0, input int r1, input int r2, input bit eol);
      return {eol, W'(r2), W'(r1), W'(r0)};
   endfunction

   // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         out_rdy = (rdy_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      end
   end

   // Monitor: handshake rules, stall stability and in-order scoreboard compare.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && !ignore) begin
            if (prev_stall) begin
               checks++;
               if (!out_vld || out_data !== prev_data) begin
                  errors++;
                  $display("FAIL stall_hold: vld=%0b data=%h, required vld=1 data=%h", out_vld, out_data, prev_data);
               end
            end
            checks++;
            if (in_rdy !== !(out_vld && !out_rdy)) begin
               errors++;
               $display("FAIL in_rdy: got %0b, required %0b", in_rdy, !(out_vld && !out_rdy));
            end
            if (out_vld && out_rdy) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_out: got eol=%0b data=%h with nothing expected", out_eol, out_data);
               end else begin
                  exp_v = exp_q.pop_front();
                  if ({out_eol, out_data} !== exp_v) begin
                     errors++;
                     $display("FAIL out_word: got eol=%0b data=%h, required eol=%0b data=%h",
                              out_eol, out_data, exp_v[EW-1], exp_v[EW-2:0]);
                  end
               end
            end
         end
         prev_stall = out_vld && !out_rdy;
         prev_data  = out_data;
      end
   end

   task automatic send(input int d, input bit sof, input int lw, input bit bd);
      int  t = 0;
      bit  acc = 1'b0;
      in_data        = W'(d);
      in_sof         = sof;
      in_vld         = 1'b1;
      cfg_line_words = (AW + 1)'(lw);
      cfg_border     = bd;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = in_rdy;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: word %0d not accepted in %0d cycles", d, t);
      end
      in_vld = 1'b0;
      in_sof = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (out_vld !== 1'b0 || out_eol !== 1'b0 || out_data !== '0 || in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL %s: vld=%0b eol=%0b data=%h rdy=%0b, required 0 0 0 1",
                  name, out_vld, out_eol, out_data, in_rdy);
      end
   endtask

   task automatic run_base(input string name);
      for (int n = 0; n < 8; n++) exp_q.push_back(mk(n, n + 4, n + 8, (n % 4) == 3));
      for (int j = 0; j < 16; j++) send(j, j == 0, 4, 1'b0);
      drain(name);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset_state");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_base("suppress");

      for (int j = 0; j < 16; j++) begin
         if (j < 4)      exp_q.push_back(mk(j, j, j, (j % 4) == 3));
         else if (j < 8) exp_q.push_back(mk(j - 4, j - 4, j, (j % 4) == 3));
         else            exp_q.push_back(mk(j - 8, j - 4, j, (j % 4) == 3));
      end
      for (int j = 0; j < 16; j++) send(j, j == 0, 4, 1'b1);
      drain("replicate");

      rdy_mode = 1;
      run_base("backpressure");
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;

      for (int j = 0; j < 6; j++) send(50 + j, j == 0, 4, 1'b0);
      exp_q.push_back(mk(100, 102, 104, 1'b0));
      exp_q.push_back(mk(101, 103, 105, 1'b1));
      exp_q.push_back(mk(102, 104, 106, 1'b0));
      exp_q.push_back(mk(103, 105, 107, 1'b1));
      for (int j = 0; j < 8; j++) send(100 + j, j == 0, 2, 1'b0);
      drain("resync");

      ignore = 1'b1;
      for (int j = 0; j < 10; j++) send(j, j == 0, 4, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ignore = 1'b0;
      run_base("after_reset");

      for (int n = 0; n < 8; n++) exp_q.push_back(mk(200 + n, 208 + n, 216 + n, n == 7));
      for (int j = 0; j < 24; j++) send(200 + j, j == 0, 0, 1'b0);
      drain("lw_zero");

      for (int j = 0; j < 8; j++) exp_q.push_back(mk(300 + j, 300 + j, 300 + j, j == 7));
      for (int j = 0; j < 8; j++) send(300 + j, j == 0, 15, 1'b1);
      drain("lw_clamp");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/swin_lbuf_k.md
Name: swin_lbuf_k

Overview:
- Parametrised successor to the 3-line sliding-window wrapper.
- Buffers K-1 previous image lines in K-1 simple-dual-port RAMs. For each accepted input word it emits K vertically aligned words (top = oldest line, bottom = current input).
- Adds runtime line length, frame-start resync, top-border replicate/suppress mode, and valid/ready backpressure on both sides.
- Sits between the pixel stream source and the window compute array.

Parameters:
- WORD_W, 128, bits per input word (16 pixels x 8 bit).
- K, 3, window rows (2..8); the block instantiates K-1 line RAMs.
- MAX_LINE_WORDS, 512, RAM depth in words.
- ADDR_W, 9, clog2(MAX_LINE_WORDS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_line_words  in  ADDR_W+1  words per line; sampled on an accepted in_sof word.
- cfg_border  in  1  0 = suppress, 1 = replicate; sampled on an accepted in_sof word.
- in_data  in  WORD_W  input word.
- in_vld  in  1  input valid.
- in_sof  in  1  first word of a frame; qualified by in_vld.
- in_rdy  out  1  input ready.
- out_data  out  K*WORD_W  window column; slice [WORD_W*i +: WORD_W] is row i, i=0 oldest.
- out_vld  out  1  output valid.
- out_eol  out  1  marks the last word of a line.
- out_rdy  in  1  downstream ready.

Behaviour:
- Reset values: out_vld=0, out_eol=0, out_data=0, in_rdy=1. Column, row and RAM-select counters reset to 0. line_words resets to MAX_LINE_WORDS; border resets to 0. RAM contents are not reset.
- adv = !out_vld || out_rdy. in_rdy = adv (combinational). An input word is accepted when in_vld && in_rdy.
- Pipeline has two stages:
  - S0 registers the accepted word and flags, and issues a RAM read at col with RAM enable = adv.
  - S1 (output register) loads on adv.
- Latency is 2 cycles from acceptance to out_vld with no stall. When stalled, all stages and RAM outputs hold, and out_data is stable while out_vld && !out_rdy.
- Write path: the accepted word is written to RAM[wsel] at address col in the same cycle it is read. RAMs are read-first, so the old content is returned.
- Output ordering: S1 rotates the RAM outputs so row 0 is the oldest stored line and row K-2 is the newest. Row K-1 is the S0 word.
- Counters:
  - col increments per accepted word.
  - At col == line_words-1: col goes to 0, wsel goes to (wsel+1) mod (K-1), row saturates at K-1, and out_eol is set on that word.
- in_sof on an accepted word:
  - col, row and wsel are treated as 0 for that word.
  - line_words is loaded first: 0 or values > MAX_LINE_WORDS clamp to MAX_LINE_WORDS.
  - border is loaded.
  - A partial line in progress is discarded with no flush.
- Border mode 0: a word produces out_vld only if row == K-1 at acceptance. Earlier words are written to RAM but not emitted.
- Border mode 1: every word is emitted. Rows i < K-1-row are replaced by the oldest valid row, i.e. the first line of the frame.
- Reset mid-operation: in-flight words are dropped and the next word must carry in_sof. A non-sof word after reset is processed with the reset defaults (line_words=MAX, border=0).
- Simultaneous end-of-line and in_sof on the same word: in_sof wins; counters restart at col=1 after that word.

Decomposition:
- swin_pkg: localparams SWIN_WORD_W=128, SWIN_K_MAX=8, and border-mode constants BORDER_SUPPRESS=0, BORDER_REPLICATE=1.
- Sub-module swin_lb_ram: simple dual-port, read-first, 1-cycle registered read with read enable, depth MAX_LINE_WORDS, width WORD_W. Instantiated K-1 times via generate.

Test Plan:
- K=3, line_words=4, border=0. Send 16 words with value = index, in_sof on word 0, out_rdy=1.
  -> 8 outputs, the first when the word-8 input is 2 cycles old. Output n (n=0..7): rows = {n, n+4, n+8}. out_eol on outputs 3 and 7.
- Same stimulus with border=1.
  -> 16 outputs. Line 0 rows = {w, w, w}; line 1 rows = {w-4, w-4, w}; thereafter identical to the previous test.
- out_rdy toggling 1,0,0,1 repeatedly in the first test.
  -> same 8 values in order, with out_data held stable during stalls. in_rdy=0 exactly when out_vld && !out_rdy.
- After 6 words, assert in_sof with line_words=2, then send 8 words (100..107).
  -> the old partial line is discarded. Border=0 outputs: {100,102,104}, {101,103,105}, {102,104,106}, {103,105,107}.
- rst_n pulsed low for 1 cycle while outputs are streaming.
  -> out_vld=0 asynchronously and in_rdy=1. After a new sof the first test's pattern repeats exactly.
- cfg_line_words=0 at sof with MAX_LINE_WORDS=8 (test build).
  -> treated as 8; out_eol every 8th output.
